// File: rtl/seg_bus_rx.sv
// seg_bus_rx: debounces a multiplexed active-low seven-segment bus and decodes it into hex nibbles on a valid/ready output.
// Optional macro SEG_RX_DP_EN: include the decimal point in the stability compare and report it on out_dp.
module seg_bus_rx #(
    parameter int NUM_SEG    = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SEG*8-1:0]   seg_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [NUM_SEG*4-1:0]   out_digits,
    output logic [NUM_SEG-1:0]     out_dp,
    output logic [NUM_SEG-1:0]     out_err,
    output logic                   overrun
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYC - 1);
`ifdef SEG_RX_DP_EN
    localparam logic [7:0] DIG_MASK = 8'hFF;
`else
    localparam logic [7:0] DIG_MASK = 8'h7F;
`endif
    localparam logic [NUM_SEG*8-1:0] BUS_MASK = {NUM_SEG{DIG_MASK}};

    typedef enum logic {SETTLE, STABLE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_SEG*8-1:0]    smp_q, smp_d;
    logic [NUM_SEG*8-1:0]    last_q, last_d;
    logic                    last_vld_q, last_vld_d;
    logic                    out_valid_q, out_valid_d;
    logic [NUM_SEG*4-1:0]    digits_q, digits_d;
    logic [NUM_SEG-1:0]      err_q, err_d;
    logic                    overrun_q, overrun_d;

    logic                    match;
    logic                    stable_hit;
    logic                    emit_new;
    logic                    xfer;
    logic                    load;
    logic [NUM_SEG*4-1:0]    dec_digits;
    logic [NUM_SEG-1:0]      dec_err;
    logic [4:0]              dec_word [NUM_SEG];

    // Returns {err, nibble}; unknown patterns (blank included) decode to 0 with err set.
    function automatic logic [4:0] dec_digit(input logic [6:0] p);
        logic [4:0] r;
        unique case (p)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_dec
        assign dec_word[gi]          = dec_digit(smp_q[8*gi +: 7]);
        assign dec_digits[4*gi +: 4] = dec_word[gi][3:0];
        assign dec_err[gi]           = dec_word[gi][4];
    end

    assign smp_d = seg_in;
    assign match = ((seg_in ^ smp_q) & BUS_MASK) == '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stable_hit = 1'b0;
        unique case (state_q)
            SETTLE: begin
                if (!match) begin
                    cnt_d = '0;
                end else if (cnt_q >= CNT_TOP) begin
                    state_d    = STABLE;
                    stable_hit = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE: begin
                if (!match) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: emission, handshake and overrun
    always_comb begin
        emit_new    = stable_hit && !(last_vld_q && ((smp_q & BUS_MASK) == last_q));
        xfer        = out_valid_q && out_ready;
        load        = emit_new && (!out_valid_q || xfer);
        last_d      = emit_new ? (smp_q & BUS_MASK) : last_q;
        last_vld_d  = last_vld_q | emit_new;
        out_valid_d = load | (out_valid_q & ~xfer);
        overrun_d   = overrun_q | (emit_new & ~load);
        digits_d    = load ? dec_digits : digits_q;
        err_d       = load ? dec_err : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q       <= '1;
            last_q      <= '0;
            last_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            digits_q    <= '0;
            err_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            smp_q       <= smp_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            out_valid_q <= out_valid_d;
            digits_q    <= digits_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SEG_RX_DP_EN
    logic [NUM_SEG-1:0] dp_q, dp_d, dec_dp;

    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_dp
        assign dec_dp[gi] = ~smp_q[8*gi + 7];
    end

    assign dp_d = load ? dec_dp : dp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_q <= '0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign out_dp = dp_q;
`else
    assign out_dp = '0;
`endif

    assign out_valid  = out_valid_q;
    assign out_digits = digits_q;
    assign out_err    = err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg_bus_rx.sv
// Testbench for seg_bus_rx: directed scenarios followed by random bus traffic checked against a run-length reference model.
module tb_seg_bus_rx;

    localparam int N = 6;
    localparam int S = 4;
`ifdef SEG_RX_DP_EN
    localparam logic [7:0] DMASK = 8'hFF;
`else
    localparam logic [7:0] DMASK = 8'h7F;
`endif
    localparam logic [7:0] PAT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    localparam logic [8*N-1:0] ALL_C0 = {N{8'hC0}};
    localparam logic [8*N-1:0] ALL_F9 = {N{8'hF9}};
    localparam logic [8*N-1:0] ALL_A4 = {N{8'hA4}};
    localparam logic [8*N-1:0] ALL_88 = {N{8'h88}};
    localparam logic [8*N-1:0] W654321 = {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    localparam logic [8*N-1:0] WGLITCH = {8'h82, 8'h92, 8'h99, 8'h88, 8'hA4, 8'hF9};
    localparam logic [8*N-1:0] WBLANK1 = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hC0};
    localparam logic [8*N-1:0] WDP0    = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40};

    logic               clk = 1'b0;
    logic               rst;
    logic [8*N-1:0]     seg_in;
    logic               out_ready;
    logic               out_valid;
    logic [4*N-1:0]     out_digits;
    logic [N-1:0]       out_dp;
    logic [N-1:0]       out_err;
    logic               overrun;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state
    logic [8*N-1:0] m_run_val;
    int             m_run_len;
    logic [8*N-1:0] m_last;
    bit             m_last_vld;
    bit             m_valid;
    logic [4*N-1:0] m_digits;
    logic [N-1:0]   m_dp;
    logic [N-1:0]   m_err;
    bit             m_ovr;
    int             m_emits;

    seg_bus_rx #(.NUM_SEG(N), .STABLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_digits (out_digits),
        .out_dp     (out_dp),
        .out_err    (out_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [8*N-1:0] mask_of(input logic [8*N-1:0] s);
        return s & {N{DMASK}};
    endfunction

    function automatic void ref_decode(input logic [8*N-1:0] s, output logic [4*N-1:0] d,
                                       output logic [N-1:0] dp, output logic [N-1:0] e);
        d  = '0;
        dp = '0;
        e  = '0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] b;
            bit hit;
            b   = s[8*i +: 8];
            hit = 0;
            for (int j = 0; j < 16; j++) begin
                if (b[6:0] == PAT[j][6:0]) begin
                    d[4*i +: 4] = j[3:0];
                    hit = 1;
                end
            end
            if (!hit) e[i] = 1'b1;
`ifdef SEG_RX_DP_EN
            dp[i] = ~b[7];
`endif
        end
    endfunction

    function automatic logic [8*N-1:0] rand_word();
        logic [8*N-1:0] w;
        for (int i = 0; i < N; i++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 19);
            if (r < 16)      b = PAT[r];
            else if (r < 18) b = 8'hFF;
            else             b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b[7] = 1'b0;
            w[8*i +: 8] = b;
        end
        return w;
    endfunction

    // Model one clock edge: a value is "stable" once it has been seen on S+1 consecutive samples.
    task automatic model_edge(input logic [8*N-1:0] s, input logic rdy, input logic r);
        logic [8*N-1:0] mv;
        if (r) begin
            m_valid    = 0;
            m_digits   = '0;
            m_dp       = '0;
            m_err      = '0;
            m_ovr      = 0;
            m_last_vld = 0;
            m_run_val  = mask_of('1);
            m_run_len  = 1;
        end else begin
            mv = mask_of(s);
            if (mv == m_run_val) begin
                if (m_run_len < S + 2) m_run_len++;
            end else begin
                m_run_val = mv;
                m_run_len = 1;
            end
            if (m_valid && rdy) m_valid = 0;
            if (m_run_len == S + 1 && !(m_last_vld && mv == m_last)) begin
                m_last     = mv;
                m_last_vld = 1;
                if (!m_valid) begin
                    ref_decode(s, m_digits, m_dp, m_err);
                    m_valid = 1;
                    m_emits++;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, model the rising edge, check 1 time unit later.
    task automatic step(input logic [8*N-1:0] s, input logic rdy, input logic r);
        seg_in    = s;
        out_ready = rdy;
        rst       = r;
        @(posedge clk);
        model_edge(s, rdy, r);
        #1;
        chk("valid",   64'(out_valid),  64'(m_valid));
        chk("digits",  64'(out_digits), 64'(m_digits));
        chk("dp",      64'(out_dp),     64'(m_dp));
        chk("err",     64'(out_err),    64'(m_err));
        chk("overrun", 64'(overrun),    64'(m_ovr));
        @(negedge clk);
    endtask

    initial begin
        logic [8*N-1:0] pool [4];
        logic [8*N-1:0] w;
        int e0;
        int hold;
        m_emits   = 0;
        m_run_val = '1;
        m_run_len = 1;
        m_last    = '0;
        rst       = 1'b1;
        seg_in    = ALL_C0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        step(ALL_C0, 1'b0, 1'b1);
        step(ALL_C0, 1'b0, 1'b1);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));

        // All zeros: valid after S+1 edges, then one transfer and silence
        for (int i = 0; i < S + 1; i++) step(ALL_C0, 1'b0, 1'b0);
        chk("tp1_valid", 64'(out_valid), 64'(1));
        chk("tp1_digits", 64'(out_digits), 64'(0));
        chk("tp1_err", 64'(out_err), 64'(0));
        for (int i = 0; i < 7; i++) step(ALL_C0, 1'b1, 1'b0);
        chk("tp1_quiet", 64'(out_valid), 64'(0));

        // 654321: single emission
        e0 = m_emits;
        for (int i = 0; i < S + 1; i++) step(W654321, 1'b1, 1'b0);
        chk("tp2_valid", 64'(out_valid), 64'(1));
        chk("tp2_digits", 64'(out_digits), 64'h654321);
        for (int i = 0; i < 4; i++) step(W654321, 1'b1, 1'b0);
        chk("tp2_single", 64'(m_emits - e0), 64'(1));
        chk("tp2_cleared", 64'(out_valid), 64'(0));

        // Short glitch then revert: nothing emitted
        e0 = m_emits;
        for (int i = 0; i < 2; i++) step(WGLITCH, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(W654321, 1'b1, 1'b0);
        chk("tp3_none", 64'(m_emits - e0), 64'(0));
        chk("tp3_valid", 64'(out_valid), 64'(0));

        // Held output: second value is dropped and overrun sticks
        for (int i = 0; i < S + 1; i++) step(ALL_F9, 1'b0, 1'b0);
        for (int i = 0; i < S + 3; i++) step(ALL_A4, 1'b0, 1'b0);
        chk("tp4_digits", 64'(out_digits), 64'h111111);
        chk("tp4_overrun", 64'(overrun), 64'(1));
        chk("tp4_valid", 64'(out_valid), 64'(1));
        step(ALL_A4, 1'b1, 1'b0);
        chk("tp4_xfer", 64'(out_valid), 64'(0));
        chk("tp4_sticky", 64'(overrun), 64'(1));
        for (int i = 0; i < 3; i++) step(ALL_A4, 1'b1, 1'b0);
        chk("tp4_no_reemit", 64'(out_valid), 64'(0));

        // Blank digit flags an error
        for (int i = 0; i < S + 1; i++) step(WBLANK1, 1'b0, 1'b0);
        chk("tp5_err", 64'(out_err), 64'b000010);
        chk("tp5_digits", 64'(out_digits), 64'h0);
        step(WBLANK1, 1'b1, 1'b0);

        // Decimal-point-only change
        for (int i = 0; i < S + 2; i++) step(ALL_C0, 1'b1, 1'b0);
        e0 = m_emits;
        for (int i = 0; i < S + 1; i++) step(WDP0, 1'b0, 1'b0);
`ifdef SEG_RX_DP_EN
        chk("tp6_valid", 64'(out_valid), 64'(1));
        chk("tp6_dp", 64'(out_dp), 64'b000001);
`else
        chk("tp6_valid", 64'(out_valid), 64'(0));
        chk("tp6_dp", 64'(out_dp), 64'(0));
`endif
        chk("tp6_emits", 64'(m_emits - e0), 64'(out_valid));
        step(WDP0, 1'b1, 1'b0);

        // Reset discards a pending word; first stable value afterwards is emitted
        for (int i = 0; i < S + 1; i++) step(ALL_88, 1'b0, 1'b0);
        step(ALL_88, 1'b0, 1'b1);
        chk("rst_discard", 64'(out_valid), 64'(0));
        for (int i = 0; i < S + 1; i++) step(ALL_88, 1'b0, 1'b0);
        chk("rst_reemit", 64'(out_valid), 64'(1));
        chk("rst_reemit_digits", 64'(out_digits), 64'hAAAAAA);

        // Random traffic drawn mostly from a small pool so repeats and reverts occur
        for (int i = 0; i < 4; i++) pool[i] = rand_word();
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) != 0) w = pool[$urandom_range(0, 3)];
            else                           w = rand_word();
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) step(w, ($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
